// File: rtl/current_loop_pi_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// current_loop_pi_if : demand/measurement/gain inputs and PWM command outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface current_loop_pi_if #(
  parameter int DATA_W = 12,
  parameter int GAIN_W = 8
);
  logic [DATA_W-1:0] assist_req;
  logic [DATA_W-1:0] phase_meas;
  logic [GAIN_W-1:0] kp;
  logic [GAIN_W-1:0] ki;
  logic              fault_clr;
  logic [DATA_W-1:0] motor_sig;
  logic              update_strobe;
  logic              fault;
  logic [1:0]        state;

  modport master (
    output assist_req, phase_meas, kp, ki, fault_clr,
    input  motor_sig, update_strobe, fault, state
  );

  modport slave (
    input  assist_req, phase_meas, kp, ki, fault_clr,
    output motor_sig, update_strobe, fault, state
  );
endinterface
`default_nettype wire

// File: rtl/current_loop_pi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// current_loop_pi : PI motor-current regulator with anti-windup, slew limit,
//                   enable-threshold FSM and latched saturation fault.
// Rev 1.0
// ---------------------------------------------------------------------------
module current_loop_pi #(
  parameter int DATA_W    = 12,
  parameter int GAIN_W    = 8,
  parameter int FRAC_W    = 6,
  parameter int DIV_LOG2  = 4,
  parameter int ENABLE_TH = 3,
  parameter int SLEW_MAX  = 64,
  parameter int FAULT_CNT = 8
) (
  input  wire logic         c20k,
  input  wire logic         reset,
  current_loop_pi_if.slave  bus
);

  localparam int ACC_W = DATA_W + GAIN_W + 2;
  localparam int SAT_W = $clog2(FAULT_CNT + 1);

  localparam logic        [DATA_W-1:0] OUT_MAX = '1;
  localparam logic signed [ACC_W-1:0]  U_MAX   = ACC_W'(2**DATA_W - 1);
  localparam logic signed [ACC_W-1:0]  ACC_MAX = ACC_W'((2**DATA_W - 1) * (2**FRAC_W));
  localparam logic signed [DATA_W:0]   SLEW_S  = (DATA_W+1)'(SLEW_MAX);
  localparam logic        [DATA_W-1:0] SLEW_U  = DATA_W'(SLEW_MAX);
  localparam logic        [DATA_W-1:0] TH      = DATA_W'(ENABLE_TH);
  localparam logic        [SAT_W-1:0]  SAT_LIM = SAT_W'(FAULT_CNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  logic [DIV_LOG2-1:0]      presc_q;
  logic                     s2_q;
  logic [DATA_W-1:0]        assist_q;
  logic signed [DATA_W:0]   err_q;
  logic [GAIN_W-1:0]        kp_q;
  logic [GAIN_W-1:0]        ki_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        motor_q;
  logic [SAT_W-1:0]         sat_q;
  logic                     strobe_q;
  logic                     fault_q;
  state_t                   state_q;

  logic                     tick;
  logic                     enable;
  logic signed [ACC_W-1:0]  err_x;
  logic signed [ACC_W-1:0]  kp_x;
  logic signed [ACC_W-1:0]  ki_x;
  logic signed [ACC_W-1:0]  prop;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  u_sum;
  logic signed [ACC_W-1:0]  u;
  logic [DATA_W-1:0]        target;
  logic signed [DATA_W:0]   diff;
  logic [DATA_W-1:0]        motor_d;
  logic [SAT_W-1:0]         sat_d;

  assign tick   = &presc_q;
  assign enable = (assist_q > TH);

  assign err_x = {{(ACC_W-DATA_W-1){err_q[DATA_W]}}, err_q};
  assign kp_x  = {{(ACC_W-GAIN_W){1'b0}}, kp_q};
  assign ki_x  = {{(ACC_W-GAIN_W){1'b0}}, ki_q};

  always_comb begin
    prop    = err_x * kp_x;
    acc_sum = acc_q + err_x * ki_x;
    // Integrator clamps instead of wrapping so it can never wind past full scale
    if (acc_sum[ACC_W-1])
      acc_d = '0;
    else if (acc_sum > ACC_MAX)
      acc_d = ACC_MAX;
    else
      acc_d = acc_sum;

    u_sum = prop + acc_d;
    u     = u_sum >>> FRAC_W;

    if (u[ACC_W-1])
      target = '0;
    else if (u > U_MAX)
      target = OUT_MAX;
    else
      target = u[DATA_W-1:0];

    diff = $signed({1'b0, target}) - $signed({1'b0, motor_q});
    if (diff > SLEW_S)
      motor_d = motor_q + SLEW_U;
    else if (diff < -SLEW_S)
      motor_d = motor_q - SLEW_U;
    else
      motor_d = target;

    sat_d = (u >= U_MAX) ? sat_q + 1'b1 : '0;
  end

  always_ff @(posedge c20k or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      s2_q     <= 1'b0;
      assist_q <= '0;
      err_q    <= '0;
      kp_q     <= '0;
      ki_q     <= '0;
      acc_q    <= '0;
      motor_q  <= '0;
      sat_q    <= '0;
      strobe_q <= 1'b0;
      fault_q  <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      presc_q  <= presc_q + 1'b1;
      s2_q     <= tick;
      strobe_q <= 1'b0;

      if (tick) begin
        assist_q <= bus.assist_req;
        kp_q     <= bus.kp;
        ki_q     <= bus.ki;
        err_q    <= $signed({1'b0, bus.assist_req}) - $signed({1'b0, bus.phase_meas});
      end

      if (state_q == ST_FAULT) begin
        if (bus.fault_clr) begin
          state_q <= ST_IDLE;
          fault_q <= 1'b0;
        end
      end else if (s2_q) begin
        if (enable) begin
          // IDLE holds motor/acc at zero, so the first RUN update slews from 0
          strobe_q <= 1'b1;
          if (sat_d == SAT_LIM) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
            motor_q <= '0;
            acc_q   <= '0;
            sat_q   <= '0;
          end else begin
            state_q <= ST_RUN;
            motor_q <= motor_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
          end
        end else begin
          strobe_q <= (state_q == ST_RUN);
          state_q  <= ST_IDLE;
          motor_q  <= '0;
          acc_q    <= '0;
          sat_q    <= '0;
        end
      end
    end
  end

  assign bus.motor_sig     = motor_q;
  assign bus.update_strobe = strobe_q;
  assign bus.fault         = fault_q;
  assign bus.state         = state_q;

endmodule
`default_nettype wire
